// File: rtl/median_window_feeder_if.sv
// Handshake and sample bus between the pixel source, the window feeder and the median unit.
interface median_window_feeder_if #(
  parameter int W = 8
);
  logic [W-1:0] PIX;
  logic         PIX_VALID;
  logic         PIX_READY;
  logic         SOF;
  logic [W-1:0] DO;
  logic         DSO;
  logic         MED_DONE;
  logic         WIN_ERR;

  modport slave (
    input  PIX, PIX_VALID, SOF, MED_DONE,
    output PIX_READY, DO, DSO, WIN_ERR
  );

  modport master (
    output PIX, PIX_VALID, SOF, MED_DONE,
    input  PIX_READY, DO, DSO, WIN_ERR
  );
endinterface

// File: rtl/median_window_feeder.sv
// 3x3 window builder for the 9-tap median filter: serialises each interior window as 9 strobed samples.
// Optional WAIT timeout with sticky WIN_ERR is enabled by defining WIN_TIMEOUT_EN.
module median_window_feeder #(
  parameter int W       = 8,
  parameter int LINE_W  = 640,
  parameter int TIMEOUT = 64
) (
  input  logic                 CLK,
  input  logic                 nRST,
  median_window_feeder_if.slave bus
);
  localparam int CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

  if (LINE_W < 3 || TIMEOUT < 1) begin : g_bad_param
    $error("median_window_feeder: LINE_W must be >= 3 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, EMIT, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [1:0]    row;
  logic [3:0]    k;
  logic [W-1:0]  sample;
  logic          strobe;

  logic [W-1:0]  lb0 [LINE_W];
  logic [W-1:0]  lb1 [LINE_W];
  logic [W-1:0]  win [9];
  logic [W-1:0]  nwin [9];

  logic          ready;
  logic          accept;
  logic [CW-1:0] col_eff;
  logic [1:0]    row_eff;
  logic [CW-1:0] col_nxt;
  logic [1:0]    row_nxt;
  logic          win_done;

  assign ready         = (state == IDLE);
  assign accept        = bus.PIX_VALID && ready;
  assign bus.PIX_READY = ready;
  assign bus.DO        = sample;
  assign bus.DSO       = strobe;

  // SOF forces the accepted pixel to (0,0) before any position-dependent decision.
  always_comb begin
    col_eff  = bus.SOF ? '0 : col;
    row_eff  = bus.SOF ? 2'd0 : row;
    col_nxt  = col_eff + CW'(1);
    row_nxt  = row_eff;
    if (col_eff == CW'(LINE_W - 1)) begin
      col_nxt = '0;
      row_nxt = (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
    end
    win_done = (row_eff == 2'd2) && (col_eff >= CW'(2));
    for (int r = 0; r < 3; r++) begin
      nwin[r*3]     = win[r*3 + 1];
      nwin[r*3 + 1] = win[r*3 + 2];
    end
    nwin[2] = lb1[col_eff];
    nwin[5] = lb0[col_eff];
    nwin[8] = bus.PIX;
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int i = 0; i < 9; i++) win[i] <= nwin[i];
      lb1[col_eff] <= lb0[col_eff];
      lb0[col_eff] <= bus.PIX;
    end
  end

`ifdef WIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          err;
  assign bus.WIN_ERR = err;
`else
  assign bus.WIN_ERR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      col    <= '0;
      row    <= 2'd0;
      k      <= 4'd0;
      sample <= '0;
      strobe <= 1'b0;
`ifdef WIN_TIMEOUT_EN
      tcnt   <= '0;
      err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            col <= col_nxt;
            row <= row_nxt;
`ifdef WIN_TIMEOUT_EN
            if (bus.SOF) err <= 1'b0;
`endif
            if (win_done) begin
              state  <= EMIT;
              k      <= 4'd0;
              sample <= nwin[0];
              strobe <= 1'b1;
            end
          end
        end
        // k indexes the sample currently on DO; the next one is loaded from the stored window.
        EMIT: begin
          if (k == 4'd8) begin
            state  <= WAIT;
            k      <= 4'd0;
            strobe <= 1'b0;
`ifdef WIN_TIMEOUT_EN
            tcnt   <= '0;
`endif
          end else begin
            k      <= k + 4'd1;
            sample <= win[k + 4'd1];
          end
        end
        WAIT: begin
          if (bus.MED_DONE) begin
            state <= IDLE;
          end
`ifdef WIN_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT - 1)) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_median_window_feeder.sv
// Directed bench for median_window_feeder with LINE_W=4: window contents, wrap, SOF, backpressure, reset, timeout.
module tb_median_window_feeder;
  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  median_window_feeder_if #(.W(8)) bus();

  median_window_feeder #(.W(8), .LINE_W(4), .TIMEOUT(64)) dut (
    .CLK (clk),
    .nRST(nrst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef logic [0:8][7:0] win_t;
  typedef struct {
    logic       rst;
    logic [7:0] pix;
    logic       sof;
    logic       en;
    win_t       win;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input int p, input logic s, input logic e, input win_t w);
    vec_t v;
    v.rst = r; v.pix = p[7:0]; v.sof = s; v.en = e; v.win = w;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    bus.PIX_VALID = 1'b0; bus.SOF = 1'b0; bus.MED_DONE = 1'b0; bus.PIX = '0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.PIX_READY !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({tag, "_ready_timeout"}, 0, 1);
  endtask

  // Present one pixel, let it be accepted, then check the window (or its absence) and handshake.
  task automatic send(input logic [7:0] p, input logic s, input logic en, input win_t w, input string tag);
    bus.PIX = p; bus.SOF = s; bus.PIX_VALID = 1'b1;
    wait_ready(tag);
    @(negedge clk);
    bus.PIX_VALID = 1'b0; bus.SOF = 1'b0;
    if (en) begin
      chk({tag, "_ready_emit"}, bus.PIX_READY, 0);
      for (int i = 0; i < 9; i++) begin
        chk($sformatf("%s_dso%0d", tag, i), bus.DSO, 1);
        chk($sformatf("%s_do%0d", tag, i), bus.DO, w[i]);
        @(negedge clk);
      end
      chk({tag, "_dso_drop"}, bus.DSO, 0);
      chk({tag, "_ready_wait"}, bus.PIX_READY, 0);
      repeat (4) @(negedge clk);
      bus.MED_DONE = 1'b1;
      @(negedge clk);
      bus.MED_DONE = 1'b0;
      chk({tag, "_ready_done"}, bus.PIX_READY, 1);
      chk({tag, "_dso_done"}, bus.DSO, 0);
    end else begin
      chk({tag, "_no_dso"}, bus.DSO, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    win_t w;
    logic e;
    bus.PIX = '0; bus.PIX_VALID = 1'b0; bus.SOF = 1'b0; bus.MED_DONE = 1'b0;

    // Reset state while nRST is held low
    @(negedge clk);
    chk("rst_ready", bus.PIX_READY, 1);
    chk("rst_dso", bus.DSO, 0);
    chk("rst_do", bus.DO, 0);
    chk("rst_err", bus.WIN_ERR, 0);

    // Basic windows and line wrap: 1..15, windows after 11, 12 and 15
    for (int p = 1; p <= 15; p++) begin
      w = '0; e = 1'b0;
      if (p == 11) begin e = 1'b1; w = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11}; end
      if (p == 12) begin e = 1'b1; w = {8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12}; end
      if (p == 15) begin e = 1'b1; w = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15}; end
      tbl.push_back(mk(p == 1, p, p == 1, e, w));
    end
    // SOF mid-frame at row 2 col 1 (pixel 10): windows resume at new row 2 col 2 (pixel 20)
    for (int p = 1; p <= 20; p++) begin
      w = '0; e = 1'b0;
      if (p == 20) begin e = 1'b1; w = {8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16, 8'd18, 8'd19, 8'd20}; end
      tbl.push_back(mk(p == 1, p, (p == 1) || (p == 10), e, w));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      send(tbl[i].pix, tbl[i].sof, tbl[i].en, tbl[i].win, $sformatf("v%0d", i));
    end

    // Backpressure: PIX_VALID held high across windows; nothing lost or duplicated
    do_reset();
    begin
      int acc = 0, run = 0, dly = 0, cyc = 0, stall = 0;
      logic pend;
      logic [7:0] got[$];
      win_t exp_w [3];
      exp_w[0] = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
      exp_w[1] = {8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12};
      exp_w[2] = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
      bus.PIX = 8'd1; bus.SOF = 1'b1; bus.PIX_VALID = 1'b1;
      pend = bus.PIX_READY;
      while (cyc < 400 && !(acc == 15 && got.size() == 27 && run == 0 && dly == 0 && bus.PIX_READY)) begin
        @(negedge clk);
        cyc++;
        if (pend) begin
          acc++;
          bus.SOF = 1'b0;
          if (acc == 15) bus.PIX_VALID = 1'b0;
          else bus.PIX = bus.PIX + 8'd1;
        end
        if (!bus.PIX_READY) stall++;
        if (bus.DSO) begin
          got.push_back(bus.DO);
          run++;
        end else if (run != 0) begin
          chk("bp_dso_run", run, 9);
          run = 0;
          dly = 3;
        end
        bus.MED_DONE = (dly == 1);
        if (dly > 0) dly--;
        pend = bus.PIX_VALID && bus.PIX_READY;
      end
      bus.MED_DONE = 1'b0;
      chk("bp_finished", cyc < 400, 1);
      chk("bp_accepts", acc, 15);
      chk("bp_samples", got.size(), 27);
      chk("bp_stall_cycles", stall, 36);
      for (int i = 0; i < 27 && i < got.size(); i++)
        chk($sformatf("bp_do%0d", i), got[i], exp_w[i / 9][i % 9]);
    end

    // Reset at k=4 of a window: dropped, counters restart at (0,0)
    do_reset();
    for (int p = 1; p <= 10; p++) send(p[7:0], p == 1, 1'b0, '0, $sformatf("rm%0d", p));
    bus.PIX = 8'd11; bus.PIX_VALID = 1'b1;
    wait_ready("rm11");
    @(negedge clk);
    bus.PIX_VALID = 1'b0;
    repeat (4) @(negedge clk);
    chk("rm_dso_k4", bus.DSO, 1);
    chk("rm_do_k4", bus.DO, 6);
    nrst = 1'b0;
    #1;
    chk("rm_dso_rst", bus.DSO, 0);
    chk("rm_ready_rst", bus.PIX_READY, 1);
    chk("rm_do_rst", bus.DO, 0);
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 10; i++) send(8'(20 + i), 1'b0, 1'b0, '0, $sformatf("ra%0d", i));
    send(8'd30, 1'b0, 1'b1, {8'd20, 8'd21, 8'd22, 8'd24, 8'd25, 8'd26, 8'd28, 8'd29, 8'd30}, "ra10");

    // WAIT without MED_DONE
    do_reset();
    for (int p = 1; p <= 10; p++) send(p[7:0], p == 1, 1'b0, '0, $sformatf("to%0d", p));
    bus.PIX = 8'd11; bus.PIX_VALID = 1'b1;
    wait_ready("to11");
    @(negedge clk);
    bus.PIX_VALID = 1'b0;
    repeat (9) @(negedge clk);
    chk("to_wait_entry_ready", bus.PIX_READY, 0);
`ifdef WIN_TIMEOUT_EN
    repeat (63) @(negedge clk);
    chk("to_ready_63", bus.PIX_READY, 0);
    chk("to_err_63", bus.WIN_ERR, 0);
    @(negedge clk);
    chk("to_ready_64", bus.PIX_READY, 1);
    chk("to_err_64", bus.WIN_ERR, 1);
    send(8'd50, 1'b0, 1'b0, '0, "to_nosof");
    chk("to_err_sticky", bus.WIN_ERR, 1);
    send(8'd51, 1'b1, 1'b0, '0, "to_sof");
    chk("to_err_clear", bus.WIN_ERR, 0);
`else
    repeat (100) @(negedge clk);
    chk("to_ready_stay", bus.PIX_READY, 0);
    chk("to_err_zero", bus.WIN_ERR, 0);
    bus.MED_DONE = 1'b1;
    @(negedge clk);
    bus.MED_DONE = 1'b0;
    chk("to_ready_done", bus.PIX_READY, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
